alu_commit_stage: RTL

Commit stage directly downstream of the ALU. Captures each ALU result and flag vector through a valid/ready handshake and holds them in a two-entry skid buffer toward the register-file write port. It owns the architectural PSR register (C F L Z N), applies per-instruction flag masks, and evaluates branch conditions against the committed flags.

---
 rtl/alu_commit_stage.sv | 128 ++++++++++++
 1 files changed

// File: rtl/alu_commit_stage.sv
// ALU commit stage: two-entry skid buffer toward the register file,
// architectural PSR ownership and branch resolution on committed flags.
module alu_commit_stage #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic [4:0]        alu_psr,
    input  logic [4:0]        psr_mask,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic              dest_we,
    input  logic              is_branch,
    input  logic [3:0]        cond,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [WIDTH-1:0]  wb_data,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              wb_we,
    output logic [4:0]        psr_q,
    output logic              branch_taken,
    output logic              branch_valid
);

    logic              head_v;
    logic [WIDTH-1:0]  head_data;
    logic [ADDR_W-1:0] head_addr;
    logic              head_we;
    logic              skid_v;
    logic [WIDTH-1:0]  skid_data;
    logic [ADDR_W-1:0] skid_addr;
    logic              skid_we;

    logic acc;
    logic drain;
    logic hit;

    assign in_ready = !(head_v && skid_v) && !flush;
    assign acc      = in_valid && in_ready;
    assign drain    = head_v && wb_ready;

    assign wb_valid = head_v;
    assign wb_data  = head_data;
    assign wb_addr  = head_addr;
    assign wb_we    = head_v && head_we;

    // PSR bits: 0 C, 1 F, 2 L, 3 Z, 4 N
    always_comb begin
        hit = 1'b0;
        unique case (cond)
            4'h0: hit = psr_q[3];
            4'h1: hit = !psr_q[3];
            4'h2: hit = psr_q[0];
            4'h3: hit = !psr_q[0];
            4'h4: hit = psr_q[2];
            4'h5: hit = !psr_q[2];
            4'h6: hit = psr_q[4];
            4'h7: hit = !psr_q[4];
            4'h8: hit = psr_q[1];
            4'h9: hit = !psr_q[1];
            4'hA: hit = !psr_q[2] && !psr_q[3];
            4'hB: hit = psr_q[2] || psr_q[3];
            4'hC: hit = !psr_q[4] && !psr_q[3];
            4'hD: hit = psr_q[4] || psr_q[3];
            4'hE: hit = 1'b1;
            4'hF: hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_v    <= 1'b0;
            head_data <= '0;
            head_addr <= '0;
            head_we   <= 1'b0;
            skid_v    <= 1'b0;
            skid_data <= '0;
            skid_addr <= '0;
            skid_we   <= 1'b0;
        end else if (flush) begin
            head_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (drain && skid_v) begin
            head_v    <= 1'b1;
            head_data <= skid_data;
            head_addr <= skid_addr;
            head_we   <= skid_we;
            skid_v    <= acc;
            if (acc) begin
                skid_data <= alu_result;
                skid_addr <= dest_addr;
                skid_we   <= dest_we;
            end
        end else if (!head_v || drain) begin
            head_v <= acc;
            if (acc) begin
                head_data <= alu_result;
                head_addr <= dest_addr;
                head_we   <= dest_we;
            end
        end else if (acc) begin
            skid_v    <= 1'b1;
            skid_data <= alu_result;
            skid_addr <= dest_addr;
            skid_we   <= dest_we;
        end
    end

    // Branches resolve against the PSR as it stood before this accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psr_q        <= 5'b0;
            branch_valid <= 1'b0;
            branch_taken <= 1'b0;
        end else begin
            branch_valid <= acc && is_branch;
            branch_taken <= acc && is_branch && hit;
            if (acc) begin
                psr_q <= (psr_q & ~psr_mask) | (alu_psr & psr_mask);
            end
        end
    end

endmodule
